// File: rtl/shot_renderer_pkg.sv
// Shared definitions for the shot renderer: 640x480 geometry, palette,
// state/result encodings and the Q.4 fixed-point helper.
package shot_renderer_pkg;

    localparam int HD        = 640;
    localparam int VD        = 480;
    localparam int FRAC_BITS = 4;

    localparam logic [11:0] COL_BLANK = 12'h000;
    localparam logic [11:0] COL_BALL  = 12'hF80;
    localparam logic [11:0] COL_MAKE  = 12'h0F0;
    localparam logic [11:0] COL_MISS  = 12'hF00;
    localparam logic [11:0] COL_RIM   = 12'hF40;
    localparam logic [11:0] COL_BOARD = 12'hFFF;
    localparam logic [11:0] COL_FLOOR = 12'h840;
    localparam logic [11:0] COL_BG    = 12'h037;
    localparam logic [11:0] COL_BAR   = 12'hFF0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLIGHT = 2'd1,
        RESULT = 2'd2
    } shot_state_t;

    typedef enum logic {
        MAKE = 1'b0,
        MISS = 1'b1
    } shot_result_t;

    // Integer pixel part of a signed Q11.4 value (floor towards -inf).
    function automatic logic signed [11:0] q4_int(input logic signed [15:0] v);
        return v[15:FRAC_BITS];
    endfunction

endpackage

// File: rtl/shot_renderer_physics.sv
// ball_physics: shot state machine, Q11.4 position / Q.4 velocity,
// make/miss detection, result hold counter and saturating score.
module ball_physics
    import shot_renderer_pkg::*;
#(
    parameter int                 BALL_X0     = 80,
    parameter int                 BALL_Y0     = 400,
    parameter int                 BALL_R      = 6,
    parameter int                 GRAVITY     = 2,
    parameter int                 HOOP_X      = 520,
    parameter int                 HOOP_W      = 40,
    parameter int                 HOOP_Y      = 200,
    parameter int                 HOLD_FRAMES = 60,
    parameter logic signed [15:0] VY_MAX      = 16'sd1024
)
(
    input  logic                clk,
    input  logic                reset,
    input  logic                frame_tick,
    input  logic                shoot,
    input  logic [7:0]          vx_in,
    input  logic [7:0]          vy_in,
    output shot_state_t         state,
    output shot_result_t        result,
    output logic signed [11:0]  ball_xi,
    output logic signed [11:0]  ball_yi,
    output logic                busy,
    output logic                made,
    output logic [7:0]          score
);
    localparam logic signed [15:0] X0_Q      = 16'(BALL_X0 * (2 ** FRAC_BITS));
    localparam logic signed [15:0] Y0_Q      = 16'(BALL_Y0 * (2 ** FRAC_BITS));
    localparam logic signed [15:0] GRAV_Q    = 16'(GRAVITY);
    localparam logic signed [11:0] HOOP_Y_I  = 12'(HOOP_Y);
    localparam logic signed [11:0] HOOP_X0_I = 12'(HOOP_X);
    localparam logic signed [11:0] HOOP_X1_I = 12'(HOOP_X + HOOP_W - 1);
    localparam logic signed [11:0] FLOOR_I   = 12'(VD - BALL_R);
    localparam logic signed [11:0] RIGHT_I   = 12'(HD);
    localparam logic signed [11:0] TOP_I     = -12'sd512;
    localparam logic [7:0]         HOLD_LAST = 8'(HOLD_FRAMES - 1);

    shot_state_t         state_r;
    shot_result_t        result_r;
    logic signed [15:0]  x_r, y_r, vx_r, vy_r;
    logic [7:0]          hold_r, score_r;
    logic                made_r, busy_r;

    logic signed [15:0]  x_nx_s, y_nx_s, vy_sum_s, vy_nx_s;
    logic signed [11:0]  xi_nx_s, yi_nx_s, yi_old_s;
    logic                make_s, miss_s;

    // Candidate next-frame kinematics and the make/miss decisions they imply.
    always_comb begin
        x_nx_s   = x_r + vx_r;
        y_nx_s   = y_r + vy_r;
        vy_sum_s = vy_r + GRAV_Q;
        if (vy_sum_s > VY_MAX) begin
            vy_nx_s = VY_MAX;
        end else begin
            vy_nx_s = vy_sum_s;
        end
        xi_nx_s  = q4_int(x_nx_s);
        yi_nx_s  = q4_int(y_nx_s);
        yi_old_s = q4_int(y_r);
        make_s   = (yi_old_s < HOOP_Y_I) && (yi_nx_s >= HOOP_Y_I) && (vy_r > 16'sd0)
                && (xi_nx_s >= HOOP_X0_I) && (xi_nx_s <= HOOP_X1_I);
        miss_s   = (yi_nx_s >= FLOOR_I) || (xi_nx_s >= RIGHT_I)
                || (xi_nx_s < 12'sd0) || (yi_nx_s < TOP_I);
    end

    // Shot FSM; simulation state only moves on frame_tick, launch is immediate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            result_r <= MISS;
            x_r      <= X0_Q;
            y_r      <= Y0_Q;
            vx_r     <= 16'sd0;
            vy_r     <= 16'sd0;
            hold_r   <= 8'd0;
            score_r  <= 8'd0;
            made_r   <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            made_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (shoot) begin
                        vx_r    <= {{8{vx_in[7]}}, vx_in};
                        vy_r    <= {{8{vy_in[7]}}, vy_in};
                        state_r <= FLIGHT;
                        busy_r  <= 1'b1;
                    end
                end
                FLIGHT: begin
                    if (frame_tick) begin
                        x_r  <= x_nx_s;
                        y_r  <= y_nx_s;
                        vy_r <= vy_nx_s;
                        // A make takes precedence over a simultaneous miss.
                        if (make_s) begin
                            made_r   <= 1'b1;
                            result_r <= MAKE;
                            state_r  <= RESULT;
                            hold_r   <= 8'd0;
                            if (score_r != 8'hFF) begin
                                score_r <= score_r + 8'd1;
                            end
                        end else if (miss_s) begin
                            result_r <= MISS;
                            state_r  <= RESULT;
                            hold_r   <= 8'd0;
                        end
                    end
                end
                RESULT: begin
                    if (frame_tick) begin
                        if (hold_r == HOLD_LAST) begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                            hold_r  <= 8'd0;
                            x_r     <= X0_Q;
                            y_r     <= Y0_Q;
                            vx_r    <= 16'sd0;
                            vy_r    <= 16'sd0;
                        end else begin
                            hold_r <= hold_r + 8'd1;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign state   = state_r;
    assign result  = result_r;
    assign ball_xi = q4_int(x_r);
    assign ball_yi = q4_int(y_r);
    assign busy    = busy_r;
    assign made    = made_r;
    assign score   = score_r;

endmodule

// File: rtl/shot_renderer.sv
// Shot renderer top: frame tick generation, pixel layering and registered RGB.
// Optional macro SCORE_BAR_EN adds a yellow score bar in the top-left corner.
module shot_renderer
    import shot_renderer_pkg::*;
#(
    parameter int                 BALL_X0     = 80,
    parameter int                 BALL_Y0     = 400,
    parameter int                 BALL_R      = 6,
    parameter int                 GRAVITY     = 2,
    parameter int                 HOOP_X      = 520,
    parameter int                 HOOP_W      = 40,
    parameter int                 HOOP_Y      = 200,
    parameter int                 HOLD_FRAMES = 60,
    parameter logic signed [15:0] VY_MAX      = 16'sd1024
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        video_on,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        shoot,
    input  logic [7:0]  vx_in,
    input  logic [7:0]  vy_in,
    output logic [11:0] rgb,
    output logic        busy,
    output logic        made,
    output logic [7:0]  score
);
    localparam logic [9:0]         RIM_X0  = 10'(HOOP_X);
    localparam logic [9:0]         RIM_X1  = 10'(HOOP_X + HOOP_W - 1);
    localparam logic [9:0]         RIM_Y0  = 10'(HOOP_Y);
    localparam logic [9:0]         RIM_Y1  = 10'(HOOP_Y + 1);
    localparam logic [9:0]         BRD_X0  = 10'(HOOP_X + HOOP_W);
    localparam logic [9:0]         BRD_X1  = 10'(HOOP_X + HOOP_W + 3);
    localparam logic [9:0]         BRD_Y0  = 10'(HOOP_Y - 60);
    localparam logic [9:0]         BRD_Y1  = 10'(HOOP_Y + 10);
    localparam logic [9:0]         FLOOR_Y = 10'(VD - 10);
    localparam logic signed [12:0] R_S     = 13'(BALL_R);
    localparam logic signed [26:0] R2_S    = 27'(BALL_R * BALL_R);

    logic               frame_tick_r;
    shot_state_t        state_s;
    shot_result_t       result_s;
    logic signed [11:0] ball_xi_s, ball_yi_s;
    logic signed [12:0] dx_s, dy_s;
    logic signed [26:0] dx_w_s, dy_w_s, dist2_s;
    logic               ball_hit_s, rim_hit_s, board_hit_s, floor_hit_s;
    logic [11:0]        ball_col_s, pix_s, rgb_r;

    // Start-of-vblank detect; the only instant the simulation advances.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_tick_r <= 1'b0;
        end else begin
            frame_tick_r <= (pixel_x == 10'd0) && (pixel_y == 10'(VD));
        end
    end

    ball_physics #(
        .BALL_X0    (BALL_X0),
        .BALL_Y0    (BALL_Y0),
        .BALL_R     (BALL_R),
        .GRAVITY    (GRAVITY),
        .HOOP_X     (HOOP_X),
        .HOOP_W     (HOOP_W),
        .HOOP_Y     (HOOP_Y),
        .HOLD_FRAMES(HOLD_FRAMES),
        .VY_MAX     (VY_MAX)
    ) u_physics (
        .clk       (clk),
        .reset     (reset),
        .frame_tick(frame_tick_r),
        .shoot     (shoot),
        .vx_in     (vx_in),
        .vy_in     (vy_in),
        .state     (state_s),
        .result    (result_s),
        .ball_xi   (ball_xi_s),
        .ball_yi   (ball_yi_s),
        .busy      (busy),
        .made      (made),
        .score     (score)
    );

    // Geometry tests for the ball disc, rim, backboard and floor.
    always_comb begin
        dx_s        = $signed({3'b000, pixel_x}) - $signed({ball_xi_s[11], ball_xi_s});
        dy_s        = $signed({3'b000, pixel_y}) - $signed({ball_yi_s[11], ball_yi_s});
        dx_w_s      = {{14{dx_s[12]}}, dx_s};
        dy_w_s      = {{14{dy_s[12]}}, dy_s};
        dist2_s     = dx_w_s * dx_w_s + dy_w_s * dy_w_s;
        ball_hit_s  = (dx_s >= -R_S) && (dx_s <= R_S) && (dy_s >= -R_S) && (dy_s <= R_S)
                   && (dist2_s <= R2_S);
        rim_hit_s   = (pixel_y >= RIM_Y0) && (pixel_y <= RIM_Y1)
                   && (pixel_x >= RIM_X0) && (pixel_x <= RIM_X1);
        board_hit_s = (pixel_x >= BRD_X0) && (pixel_x <= BRD_X1)
                   && (pixel_y >= BRD_Y0) && (pixel_y <= BRD_Y1);
        floor_hit_s = (pixel_y >= FLOOR_Y);
        case (state_s)
            RESULT:  ball_col_s = (result_s == MAKE) ? COL_MAKE : COL_MISS;
            default: ball_col_s = COL_BALL;
        endcase
    end

`ifdef SCORE_BAR_EN
    localparam logic [7:0] BAR_MAX = 8'd150;

    logic [7:0]  bar_len_s;
    logic [10:0] bar_end_s;
    logic        bar_hit_s;

    // Score bar, four pixels per point, clamped so it stays on screen.
    always_comb begin
        if (score > BAR_MAX) begin
            bar_len_s = BAR_MAX;
        end else begin
            bar_len_s = score;
        end
        bar_end_s = 11'd8 + {1'b0, bar_len_s, 2'b00};
        bar_hit_s = (pixel_y >= 10'd8) && (pixel_y <= 10'd15)
                 && (pixel_x >= 10'd8) && ({1'b0, pixel_x} < bar_end_s);
    end
`endif

    // Layer priority: ball, rim, [score bar], backboard, floor, background.
    always_comb begin
        if (!video_on) begin
            pix_s = COL_BLANK;
        end else if (ball_hit_s) begin
            pix_s = ball_col_s;
        end else if (rim_hit_s) begin
            pix_s = COL_RIM;
`ifdef SCORE_BAR_EN
        end else if (bar_hit_s) begin
            pix_s = COL_BAR;
`endif
        end else if (board_hit_s) begin
            pix_s = COL_BOARD;
        end else if (floor_hit_s) begin
            pix_s = COL_FLOOR;
        end else begin
            pix_s = COL_BG;
        end
    end

    // Single output register keeps RGB aligned with the registered syncs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_r <= 12'h000;
        end else begin
            rgb_r <= pix_s;
        end
    end

    assign rgb = rgb_r;

endmodule

// File: tb/tb_shot_renderer.sv
// Scoreboard bench for shot_renderer: stimulus queues expected outputs,
// a negedge monitor pops and compares them one clock later.
module tb_shot_renderer;

    localparam int K_RGB   = 0;
    localparam int K_BUSY  = 1;
    localparam int K_SCORE = 2;
    localparam int K_MADE  = 3;

`ifdef SCORE_BAR_EN
    localparam int BAR_COL = 'hFF0;
`else
    localparam int BAR_COL = 'h037;
`endif

    typedef struct {
        int    due;
        int    kind;
        int    exp;
        string name;
    } item_t;

    logic        clk = 1'b0;
    logic        reset, video_on, shoot;
    logic [9:0]  pixel_x, pixel_y;
    logic [7:0]  vx_in, vy_in;
    logic [11:0] rgb;
    logic        busy, made;
    logic [7:0]  score;

    item_t sb_q[$];
    item_t mon_it;
    int    mon_act;
    int    cyc = 0;
    int    chk_cnt = 0;
    int    fail_cnt = 0;
    int    made_cnt = 0;
    int    exp_made = 0;
    int    mx, my, mvx, mvy;

    shot_renderer dut (
        .clk     (clk),
        .reset   (reset),
        .video_on(video_on),
        .pixel_x (pixel_x),
        .pixel_y (pixel_y),
        .shoot   (shoot),
        .vx_in   (vx_in),
        .vy_in   (vy_in),
        .rgb     (rgb),
        .busy    (busy),
        .made    (made),
        .score   (score)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (made === 1'b1) made_cnt <= made_cnt + 1;
    end

    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            mon_it = sb_q.pop_front();
            case (mon_it.kind)
                K_RGB:   mon_act = int'(rgb);
                K_BUSY:  mon_act = int'(busy);
                K_SCORE: mon_act = int'(score);
                default: mon_act = made_cnt;
            endcase
            chk_cnt = chk_cnt + 1;
            if (mon_act != mon_it.exp) begin
                fail_cnt = fail_cnt + 1;
                $display("FAIL %s: got 0x%0h, expected 0x%0h", mon_it.name, mon_act, mon_it.exp);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push(input int kind, input int exp, input string name);
        item_t it;
        it.due  = cyc + 1;
        it.kind = kind;
        it.exp  = exp;
        it.name = name;
        sb_q.push_back(it);
    endtask

    task automatic probe(input int px, input int py, input logic von, input int exp, input string name);
        video_on = von;
        pixel_x  = 10'(px);
        pixel_y  = 10'(py);
        push(K_RGB, exp, name);
        @(negedge clk);
    endtask

    task automatic expect_out(input int kind, input int exp, input string name);
        push(kind, exp, name);
        @(negedge clk);
    endtask

    task automatic model_launch(input logic [7:0] vx8, input logic [7:0] vy8);
        mx  = 80 * 16;
        my  = 400 * 16;
        mvx = int'($signed(vx8));
        mvy = int'($signed(vy8));
    endtask

    task automatic model_step(input int n);
        for (int i = 0; i < n; i++) begin
            mx  = mx + mvx;
            my  = my + mvy;
            mvy = (mvy + 2 > 1024) ? 1024 : mvy + 2;
        end
    endtask

    task automatic do_shot(input logic [7:0] vx8, input logic [7:0] vy8);
        shoot = 1'b1;
        vx_in = vx8;
        vy_in = vy8;
        @(negedge clk);
        shoot = 1'b0;
        vx_in = 8'h00;
        vy_in = 8'h00;
        model_launch(vx8, vy8);
    endtask

    // Park the scan on the vblank start pixel for n cycles -> n frame ticks.
    task automatic run_ticks(input int n);
        video_on = 1'b0;
        pixel_x  = 10'd0;
        pixel_y  = 10'd480;
        repeat (n) @(negedge clk);
        pixel_x = 10'd1;
        pixel_y = 10'd1;
        repeat (2) @(negedge clk);
        model_step(n);
    endtask

    initial begin
        reset = 1'b1; video_on = 1'b0; shoot = 1'b0;
        pixel_x = 10'd1; pixel_y = 10'd1; vx_in = 8'h00; vy_in = 8'h00;
        repeat (2) @(negedge clk);
        video_on = 1'b1; pixel_x = 10'd80; pixel_y = 10'd400;
        push(K_RGB, 'h000, "reset_rgb");
        push(K_BUSY, 0, "reset_busy");
        expect_out(K_SCORE, 0, "reset_score");
        reset = 1'b0;
        @(negedge clk);
        chk_cnt = chk_cnt + 1;
        if (busy !== 1'b0 || score !== 8'd0) begin
            fail_cnt = fail_cnt + 1;
            $display("FAIL post_reset_direct: busy=%0b score=%0d", busy, score);
        end

        // Idle scene and layer priority
        probe(80, 400, 1'b1, 'hF80, "idle_ball_centre");
        probe(86, 400, 1'b1, 'hF80, "ball_edge_dx6");
        probe(87, 400, 1'b1, 'h037, "ball_out_dx7");
        probe(84, 404, 1'b1, 'hF80, "ball_diag_in");
        probe(85, 404, 1'b1, 'h037, "ball_diag_out");
        probe(80, 400, 1'b0, 'h000, "video_off");
        probe(650, 10, 1'b0, 'h000, "offscreen_blank");
        probe(530, 200, 1'b1, 'hF40, "rim_row0");
        probe(559, 201, 1'b1, 'hF40, "rim_row1_end");
        probe(560, 200, 1'b1, 'hFFF, "board_at_rim");
        probe(563, 140, 1'b1, 'hFFF, "board_top_right");
        probe(564, 140, 1'b1, 'h037, "board_right_out");
        probe(560, 139, 1'b1, 'h037, "board_top_out");
        probe(300, 470, 1'b1, 'h840, "floor_top");
        probe(300, 469, 1'b1, 'h037, "above_floor");
        expect_out(K_BUSY, 0, "idle_busy");

        // Make: vx=4.75, vy=-8 crosses y=200 descending at tick 96, x=536
        do_shot(8'h4C, 8'h80);
        expect_out(K_BUSY, 1, "make_busy_launch");
        run_ticks(50);
        probe(mx >>> 4, my >>> 4, 1'b1, 'hF80, "make_flight_t50");
        run_ticks(45);
        probe(mx >>> 4, my >>> 4, 1'b1, 'hF80, "make_flight_t95");
        expect_out(K_MADE, 0, "make_no_early_pulse");
        run_ticks(1);
        exp_made = exp_made + 1;
        push(K_MADE, exp_made, "make_single_pulse");
        push(K_SCORE, 1, "make_score");
        probe(536, 202, 1'b1, 'h0F0, "make_ball_green");
        run_ticks(59);
        expect_out(K_BUSY, 1, "make_hold_59");
        probe(536, 202, 1'b1, 'h0F0, "make_frozen");
        run_ticks(1);
        expect_out(K_BUSY, 0, "make_hold_done");
        probe(80, 400, 1'b1, 'hF80, "make_ball_reset");

        // Miss off the right edge: vx=7.9375, vy=-8 -> int(x)=643 at tick 71
        do_shot(8'h7F, 8'h80);
        run_ticks(70);
        probe(mx >>> 4, my >>> 4, 1'b1, 'hF80, "miss_flight_t70");
        probe(635, 141, 1'b1, 'hF80, "miss_t70_hand");
        run_ticks(1);
        push(K_BUSY, 1, "miss_busy");
        push(K_SCORE, 1, "miss_score_kept");
        push(K_MADE, exp_made, "miss_no_pulse");
        probe(637, 142, 1'b1, 'hF00, "miss_ball_red");
        shoot = 1'b1; vx_in = 8'h10; vy_in = 8'h10;
        @(negedge clk);
        shoot = 1'b0; vx_in = 8'h00; vy_in = 8'h00;
        expect_out(K_BUSY, 1, "shoot_ignored_busy");
        run_ticks(59);
        probe(637, 142, 1'b1, 'hF00, "miss_still_result");
        run_ticks(1);
        expect_out(K_BUSY, 0, "miss_hold_done");
        probe(80, 400, 1'b1, 'hF80, "miss_ball_reset");

        // Trajectory vx=4, vy=-6 checked for 5 ticks, then reset mid-flight
        do_shot(8'h40, 8'hA0);
        run_ticks(1);
        probe(84, 394, 1'b1, 'hF80, "traj_t1_hand");
        probe(91, 394, 1'b1, 'h037, "traj_t1_right");
        for (int t = 2; t <= 5; t++) begin
            run_ticks(1);
            probe(mx >>> 4, my >>> 4, 1'b1, 'hF80, "traj_centre");
            probe((mx >>> 4) + 7, my >>> 4, 1'b1, 'h037, "traj_right_out");
        end
        reset = 1'b1;
        video_on = 1'b1; pixel_x = 10'(mx >>> 4); pixel_y = 10'(my >>> 4);
        push(K_RGB, 'h000, "midflight_reset_rgb");
        push(K_BUSY, 0, "midflight_reset_busy");
        expect_out(K_SCORE, 0, "midflight_reset_score");
        reset = 1'b0;
        @(negedge clk);
        probe(80, 400, 1'b1, 'hF80, "post_reset_ball");

        // Repeat the make shot up to saturation
        for (int i = 1; i <= 255; i++) begin
            do_shot(8'h4C, 8'h80);
            run_ticks(156);
            exp_made = exp_made + 1;
            if (i == 3) begin
                expect_out(K_SCORE, 3, "score_3");
                probe(19, 12, 1'b1, BAR_COL, "bar_last_px");
                probe(8, 8, 1'b1, BAR_COL, "bar_first_px");
                probe(20, 12, 1'b1, 'h037, "bar_past_end");
                probe(8, 16, 1'b1, 'h037, "bar_below");
            end
        end
        push(K_SCORE, 255, "score_255");
        expect_out(K_MADE, exp_made, "made_count_255");
        do_shot(8'h4C, 8'h80);
        run_ticks(156);
        exp_made = exp_made + 1;
        push(K_SCORE, 255, "score_saturated");
        push(K_BUSY, 0, "sat_idle");
        expect_out(K_MADE, exp_made, "made_pulse_at_sat");

        repeat (3) @(negedge clk);
        chk_cnt = chk_cnt + 1;
        if (score !== 8'd255 || busy !== 1'b0) begin
            fail_cnt = fail_cnt + 1;
            $display("FAIL final_direct: score=%0d busy=%0b", score, busy);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, fail_cnt);
        if (fail_cnt != 0) begin
            $fatal(1, "%0d failures", fail_cnt);
        end
        $finish;
    end

endmodule
